// File: rtl/img_win_buff.sv
// img_win_buff: sliding-window pixel buffer with valid/ready handshakes, fill tracking and start-of-line restart; define IMG_WIN_BUFF_ZPAD_EN for zero-padded row edges.
module img_win_buff #(
  parameter int DATA_W = 24,
  parameter int TAPS = 3,
  localparam int CNT_W = $clog2(TAPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        image_in,
  input  logic                     in_valid,
  input  logic                     in_sol,
  output logic                     in_ready,
  output logic [DATA_W*TAPS-1:0]   image_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         fill_cnt
);
  logic [DATA_W-1:0] tap [TAPS];
  logic              acc;
  logic [CNT_W-1:0]  fill_nxt;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign fill_nxt = in_sol ? CNT_W'(1) : (fill_cnt == CNT_W'(TAPS) ? fill_cnt : fill_cnt + CNT_W'(1));
  // newest pixel lands in the MSBs
  for (genvar i = 0; i < TAPS; i++) begin : g_pack
    assign image_out[DATA_W*(TAPS-i)-1 -: DATA_W] = tap[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) tap[k] <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (acc) begin
      tap[0] <= image_in;
`ifdef IMG_WIN_BUFF_ZPAD_EN
      for (int k = 1; k < TAPS; k++) tap[k] <= in_sol ? '0 : tap[k-1];
      out_valid <= 1'b1;
`else
      for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
      out_valid <= fill_nxt == CNT_W'(TAPS);
`endif
      fill_cnt <= fill_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_img_win_buff.sv
// tb_img_win_buff: scoreboard bench; a behavioural window model pushes expected windows on accept, popped when the DUT hands a window off.
module tb_img_win_buff;
  localparam int DATA_W = 24;
  localparam int TAPS = 3;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int W = DATA_W * TAPS;
  logic              clk = 0, rst = 1;
  logic [DATA_W-1:0] image_in = '0;
  logic              in_valid = 0, in_sol = 0, out_ready = 0;
  logic              in_ready, out_valid;
  logic [W-1:0]      image_out;
  logic [CNT_W-1:0]  fill_cnt;
  int errs = 0, checks = 0;
  logic [DATA_W-1:0] m_tap [TAPS];
  int                m_fill;
  logic              m_ov;
  logic [W-1:0]      sb [$];
  logic [W-1:0]      frozen;
  logic [DATA_W-1:0] pix;
  img_win_buff #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .image_in(image_in), .in_valid(in_valid), .in_sol(in_sol),
    .in_ready(in_ready), .image_out(image_out), .out_valid(out_valid),
    .out_ready(out_ready), .fill_cnt(fill_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [W-1:0] m_win();
    logic [W-1:0] w;
    for (int k = 0; k < TAPS; k++) w[DATA_W*(TAPS-k)-1 -: DATA_W] = m_tap[k];
    return w;
  endfunction
  task automatic m_reset();
    for (int k = 0; k < TAPS; k++) m_tap[k] = '0;
    m_fill = 0;
    m_ov = 0;
    sb.delete();
  endtask
  task automatic step(input logic v, input logic s, input logic [DATA_W-1:0] d, input logic r);
    logic acc;
    @(negedge clk);
    in_valid = v; in_sol = s; image_in = d; out_ready = r;
    #1;
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("fill_cnt", W'(fill_cnt), W'(m_fill));
    chk("in_ready", W'(in_ready), W'(!m_ov || r));
    if (out_valid && r) begin
      if (sb.size() == 0) chk("sb_empty", W'(1), W'(0));
      else chk("window", image_out, sb.pop_front());
    end
    acc = v && (!m_ov || r);
    if (acc) begin
      for (int k = TAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = d;
      m_fill = s ? 1 : (m_fill == TAPS ? TAPS : m_fill + 1);
`ifdef IMG_WIN_BUFF_ZPAD_EN
      if (s) for (int k = 1; k < TAPS; k++) m_tap[k] = '0;
      m_ov = 1;
`else
      m_ov = (m_fill == TAPS);
`endif
      if (m_ov) sb.push_back(m_win());
    end else if (r) m_ov = 0;
  endtask
  initial begin
    m_reset();
    #2;
    chk("rst_image_out", image_out, '0);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_fill_cnt", W'(fill_cnt), W'(0));
    @(negedge clk); @(negedge clk);
    rst = 0;
    for (int p = 1; p <= 3; p++) step(1, 0, DATA_W'(p), 1);
    @(posedge clk); #1;
`ifndef IMG_WIN_BUFF_ZPAD_EN
    chk("first_window", image_out, 72'h000003_000002_000001);
    chk("first_valid", W'(out_valid), W'(1));
`endif
    step(1, 0, 24'h4, 1);
    @(posedge clk); #1;
`ifndef IMG_WIN_BUFF_ZPAD_EN
    chk("second_window", image_out, 72'h000004_000003_000002);
`endif
    frozen = image_out;
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 24'h5, 0);
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_frozen", image_out, frozen);
    end
    for (int p = 5; p <= 9; p++) step(1, 0, DATA_W'(p), 1);
    step(1, 1, 24'hA, 1);
    @(posedge clk); #1;
`ifndef IMG_WIN_BUFF_ZPAD_EN
    chk("sol_valid", W'(out_valid), W'(0));
`endif
    chk("sol_fill", W'(fill_cnt), W'(1));
    step(1, 0, 24'hB, 1);
    step(1, 0, 24'hC, 1);
    @(posedge clk); #1;
`ifndef IMG_WIN_BUFF_ZPAD_EN
    chk("sol_window", image_out, 72'h00000C_00000B_00000A);
`endif
    pix = 24'h100;
    for (int c = 0; c < 60; c++) begin
      logic v;
      v = 1'($urandom_range(0, 3) != 0);
      step(v, 1'($urandom_range(0, 7) == 0), pix, 1'($urandom_range(0, 2) != 0));
      if (v) pix++;
    end
    for (int p = 0; p < 4; p++) step(1, 0, 24'h200 + DATA_W'(p), 0);
    step(0, 0, 24'h0, 0);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_image_out", image_out, '0);
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_fill_cnt", W'(fill_cnt), W'(0));
    m_reset();
    @(negedge clk);
    rst = 0;
    for (int p = 1; p <= 4; p++) step(1, 0, 24'h300 + DATA_W'(p), 1);
`ifdef IMG_WIN_BUFF_ZPAD_EN
    step(1, 1, 24'h11, 1);
    @(posedge clk); #1;
    chk("zpad_valid", W'(out_valid), W'(1));
    chk("zpad_first", image_out, 72'h000011_000000_000000);
    step(1, 0, 24'h12, 1);
    @(posedge clk); #1;
    chk("zpad_second", image_out, 72'h000012_000011_000000);
`endif
    for (int c = 0; c < 3; c++) step(0, 0, 24'h0, 1);
    chk("sb_drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/img_win_buff.md
Name: img_win_buff

Overview:
- Parametrised sliding-window pixel buffer: shifts a pixel stream through TAPS registers of DATA_W bits and presents all taps in parallel as one window word for the MAC array.
- Adds valid/ready handshakes on both sides, fill tracking so only fully populated windows are emitted, and a start-of-line restart so windows never span rows.
- Sits between the image fetch path and the convolution MAC.

Parameters:
- DATA_W, 24, bits per pixel word (e.g. 3 x 8-bit RGB)
- TAPS, 3, window length in pixels; legal range 2..16
- CNT_W, $clog2(TAPS+1), width of the fill counter (derived; not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- image_in  in  DATA_W  incoming pixel
- in_valid  in  1  image_in valid
- in_sol  in  1  start-of-line marker, qualified by in_valid
- in_ready  out  1  buffer can accept image_in this cycle
- image_out  out  DATA_W*TAPS  window; tap0 (newest) in the MSBs, tap TAPS-1 (oldest) in the LSBs
- out_valid  out  1  image_out holds a window not yet consumed
- out_ready  in  1  downstream accepts window
- fill_cnt  out  CNT_W  number of valid taps, saturating at TAPS

Behaviour:
- Reset (rst=1, async): all taps = 0, fill_cnt = 0, out_valid = 0. Outputs at reset: image_out = 0, in_ready = 1.
- Reset mid-stream discards the partial window. No window is emitted until TAPS new pixels are accepted after reset deasserts.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept: acc = in_valid && in_ready. On acc:
  - tap0 <= image_in and tap[i] <= tap[i-1].
  - fill_cnt_next = in_sol ? 1 : min(fill_cnt+1, TAPS).
- No acc: taps and fill_cnt hold.
- out_valid update, in priority order:
  - on acc: out_valid <= (fill_cnt_next == TAPS);
  - else if out_ready: out_valid <= 0;
  - else hold.
- Latency: the window containing pixel N is on image_out the cycle after pixel N is accepted.
- Window registers are driven straight to image_out; there is no combinational path from image_in to image_out.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and image_out is stable.
- Simultaneous consume and accept in the same cycle (out_valid=1, out_ready=1, in_valid=1): the old window is consumed and the new window is loaded. No bubble; sustains 1 window/cycle.
- in_sol with fill_cnt = TAPS: the restart takes priority. fill_cnt becomes 1 and out_valid deasserts at the next edge unless TAPS == 1 (illegal).
- Without the optional feature, stale taps after in_sol keep their old pixel values but are never exposed in a valid window.
- in_sol while in_valid = 0 is ignored.
- fill_cnt saturates at TAPS and never wraps.

Optional Feature:
- Macro: IMG_WIN_BUFF_ZPAD_EN.
- Defined (zero-padded edge mode):
  - on an accepted in_sol pixel, tap0 <= image_in and taps 1..TAPS-1 <= 0;
  - out_valid <= 1 on every accept, regardless of fill_cnt;
  - fill_cnt still counts as specified, for status only.
  - The first window of a row is therefore {p0, 0, ..., 0}.
- Undefined: behaviour exactly as in Behaviour. No extra logic is synthesised.

Test Plan:
- Default parameters, rst pulse, then pixels 0x000001, 0x000002, 0x000003 with in_valid=1, out_ready=1 -> out_valid first high the cycle after 0x000003 is accepted, with image_out = 0x000003_000002_000001. fill_cnt goes 1, 2, 3.
- Continue with 0x000004 -> next cycle image_out = 0x000004_000003_000002, out_valid stays 1, 1 window/cycle with no bubble.
- Hold out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0, image_out frozen, no pixel lost. Release -> stream resumes with the next pixel in order.
- in_sol=1 on pixel 0x00000A when fill_cnt=3 -> fill_cnt=1 and out_valid=0. The next valid window is 0x00000C_00000B_00000A, two accepts later.
- Assert rst while out_valid=1 mid-row -> image_out=0, out_valid=0, fill_cnt=0 immediately, without waiting for a clock edge. Three fresh pixels are needed before the next window.
- IMG_WIN_BUFF_ZPAD_EN defined, in_sol on 0x000011 -> out_valid=1 next cycle with image_out = 0x000011_000000_000000. Then 0x000012 -> image_out = 0x000012_000011_000000.
